// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : LEGv8 pipeline interlock (load-use, flag-use, branch flush)
//               and fixed-latency MUL/SDIV hold sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MULDIV_LAT  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [4:0]             id_rn,
    input  logic [4:0]             id_rm,
    input  logic                   id_uses_rm,
    input  logic                   id_reads_flags,
    input  logic                   id_br_taken,
    input  logic                   ex_valid,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_memread,
    input  logic                   ex_setflags,
    input  logic                   ex_is_muldiv,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   ex_hold,
    output logic                   muldiv_start,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    // The start cycle counts toward the latency, and md_cnt==0 is the last busy cycle.
    localparam logic [3:0] C_MD_INIT = 4'(MULDIV_LAT - 2);
    localparam logic [4:0] C_XZR     = 5'd31;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_md_cnt;
    logic [3:0]             w_md_cnt_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_load_use;
    logic                   w_flag_use;

    assign w_load_use = id_valid & ex_valid & ex_memread & (ex_rd != C_XZR) &
                        ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));
    assign w_flag_use = id_valid & ex_valid & id_reads_flags & ex_setflags;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        ex_hold      = 1'b0;
        muldiv_start = 1'b0;
        md_busy      = 1'b0;
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;

        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            w_state_nxt  = ST_RUN;
            w_md_cnt_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_MD_BUSY: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    ex_hold    = 1'b1;
                    md_busy    = 1'b1;
                    if (r_md_cnt == 4'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_md_cnt_nxt = r_md_cnt - 4'd1;
                    end
                end
                default: begin
                    if (ex_valid && ex_is_muldiv) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        ex_hold      = 1'b1;
                        muldiv_start = 1'b1;
                        w_state_nxt  = ST_MD_BUSY;
                        w_md_cnt_nxt = C_MD_INIT;
                    end else if (w_load_use || w_flag_use) begin
                        // A coincident taken branch is dropped; the held instruction re-raises it.
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (id_br_taken) begin
                        ifid_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_md_cnt    <= 4'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
            if (!pc_write && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
